// File: rtl/sw_debounce.sv
// Switch input conditioner: two-flop synchroniser followed by an independent
// per-bit debouncer that emits clean levels plus one-cycle rise/fall pulses.
module sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_change
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    // Count value on which a persistent mismatch is accepted as the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] pulse_d;
    logic             change_q;
    logic             change_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            state_t           state_q;
            state_t           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             out_q;
            logic             out_d;
            logic             rise_q;
            logic             rise_d;
            logic             fall_q;
            logic             fall_d;
            logic             mismatch;
            logic             accept;

            always_comb begin
                mismatch = (sync2_q[gi] != out_q);
                accept   = 1'b0;
                state_d  = ST_STABLE;
                cnt_d    = '0;
                out_d    = out_q;
                rise_d   = 1'b0;
                fall_d   = 1'b0;

                // In STABLE the counter is known to be zero, so the first
                // mismatching sample is judged against a zero count.
                case (state_q)
                    ST_STABLE: begin
                        if (mismatch) begin
                            if (CNT_LAST == '0) begin
                                accept = 1'b1;
                            end else begin
                                state_d = ST_COUNTING;
                                cnt_d   = CNT_W'(1);
                            end
                        end
                    end
                    ST_COUNTING: begin
                        if (mismatch) begin
                            if (cnt_q == CNT_LAST) begin
                                accept = 1'b1;
                            end else begin
                                state_d = ST_COUNTING;
                                cnt_d   = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = ST_STABLE;
                    end
                endcase

                if (accept) begin
                    out_d  = sync2_q[gi];
                    rise_d = sync2_q[gi];
                    fall_d = ~sync2_q[gi];
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    state_q <= ST_STABLE;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    out_q   <= out_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign pulse_d[gi] = rise_d | fall_d;
            assign sw_out[gi]  = out_q;
            assign sw_rise[gi] = rise_q;
            assign sw_fall[gi] = fall_q;
        end
    endgenerate

    // One shared change flag, registered alongside the per-bit pulses.
    always_comb begin
        change_d = |pulse_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            change_q <= 1'b0;
        end else begin
            change_q <= change_d;
        end
    end

    assign sw_change = change_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: vector table, hand-written corner
// sequences and random stimulus against a sliding-window reference model.
module tb_sw_debounce;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = 16;

    logic         clock  = 1'b0;
    logic         reset  = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_change;

    int checks = 0;
    int errors = 0;

    sw_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .sw_out   (sw_out),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .sw_change(sw_change)
    );

    always #5 clock = ~clock;

    // Reference model: raw samples per edge; a bit flips once the last D
    // synchronised samples all disagree with the current output level.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_out;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic         m_change;

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } vec_t;

    vec_t vecs[$];

    task automatic model_clear();
        hist.delete();
        for (int k = 0; k <= D; k++) hist.push_back('0);
        m_out    = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_change = 1'b0;
    endtask

    task automatic model_edge(input logic [W-1:0] raw);
        logic [W-1:0] flip;
        flip = '0;
        for (int b = 0; b < W; b++) begin
            bit all_differ;
            all_differ = 1'b1;
            for (int k = 0; k < D; k++)
                if (hist[hist.size() - 2 - k][b] == m_out[b]) all_differ = 1'b0;
            flip[b] = all_differ;
        end
        m_rise   = flip & ~m_out;
        m_fall   = flip & m_out;
        m_change = |flip;
        m_out    = m_out ^ flip;
        hist.push_back(raw);
        if (hist.size() > D + 1) void'(hist.pop_front());
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_edge(sw_raw);
        else model_clear();
        #1;
        check("model", {19'd0, sw_out, sw_rise, sw_fall, sw_change},
              {19'd0, m_out, m_rise, m_fall, m_change});
    endtask

    task automatic add(input logic [W-1:0] raw, input logic [W-1:0] out,
                       input logic [W-1:0] rise, input logic [W-1:0] fall, input logic chg);
        vec_t v;
        v.raw  = raw;
        v.out  = out;
        v.rise = rise;
        v.fall = fall;
        v.chg  = chg;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int rises;
        int seen;
        int pat[4];

        // Edges after reset release: power-up with all pins high, then bit0
        // falls and rises again.
        for (int k = 0; k < 5; k++) add(4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'hF, 4'hF, 4'hF, 4'h0, 1'b1);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
        for (int k = 0; k < 5; k++) add(4'hE, 4'hF, 4'h0, 4'h0, 1'b0);
        add(4'hE, 4'hE, 4'h0, 4'h1, 1'b1);
        add(4'hE, 4'hE, 4'h0, 4'h0, 1'b0);
        for (int k = 0; k < 5; k++) add(4'hF, 4'hE, 4'h0, 4'h0, 1'b0);
        add(4'hF, 4'hF, 4'h1, 4'h0, 1'b1);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0);

        model_clear();
        reset  = 1'b0;
        sw_raw = 4'hF;
        #1;
        check("reset_state", {19'd0, sw_out, sw_rise, sw_fall, sw_change}, 32'd0);
        repeat (3) tick();
        check("reset_hold", {19'd0, sw_out, sw_rise, sw_fall, sw_change}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            sw_raw = vecs[i].raw;
            tick();
            check($sformatf("vec%0d", i), {19'd0, sw_out, sw_rise, sw_fall, sw_change},
                  {19'd0, vecs[i].out, vecs[i].rise, vecs[i].fall, vecs[i].chg});
            $display("vec %0d raw=%h out=%h rise=%h fall=%h chg=%0d",
                     i, sw_raw, sw_out, sw_rise, sw_fall, sw_change);
        end

        // Bounce on bit1 before it settles high.
        reset  = 1'b0;
        sw_raw = 4'h0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        pat   = '{1, 0, 1, 0};
        rises = 0;
        for (int i = 0; i < 4; i++) begin
            sw_raw[1] = pat[i][0];
            tick();
            rises += int'(sw_rise[1]);
        end
        sw_raw[1] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            rises += int'(sw_rise[1]);
        end while (!sw_out[1] && n < 20);
        check("bounce_latency", n, 6);
        repeat (2) begin
            tick();
            rises += int'(sw_rise[1]);
        end
        check("bounce_rise_count", rises, 1);
        $display("bounce: latency=%0d rises=%0d out=%h", n, rises, sw_out);

        // Three-cycle glitch on bit2, then a real step must still take the full time.
        seen      = 0;
        sw_raw[2] = 1'b1;
        repeat (3) begin
            tick();
            seen += int'(sw_out[2] | sw_rise[2] | sw_fall[2] | sw_change);
        end
        sw_raw[2] = 1'b0;
        repeat (8) begin
            tick();
            seen += int'(sw_out[2] | sw_rise[2] | sw_fall[2] | sw_change);
        end
        check("glitch_no_change", seen, 0);
        sw_raw[2] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!sw_out[2] && n < 20);
        check("glitch_restart_latency", n, 6);
        $display("glitch: seen=%0d latency=%0d out=%h", seen, n, sw_out);

        // Bit0 rises and bit3 falls on the same edge.
        sw_raw[3] = 1'b1;
        repeat (8) tick();
        sw_raw[0] = 1'b1;
        sw_raw[3] = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!sw_change && n < 20);
        check("simul_latency", n, 6);
        check("simul_pulses", {23'd0, sw_rise, sw_fall, sw_change}, {23'd0, 4'h1, 4'h8, 1'b1});
        tick();
        check("simul_pulse_clear", {23'd0, sw_rise, sw_fall, sw_change}, 32'd0);
        $display("simul: latency=%0d out=%h", n, sw_out);

        // Asynchronous reset in the middle of a count.
        sw_raw = 4'h8;
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check("async_reset", {19'd0, sw_out, sw_rise, sw_fall, sw_change}, 32'd0);
        tick();
        reset = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (sw_out != 4'h8 && n < 20);
        check("post_reset_latency", n, 6);
        $display("async reset: latency=%0d out=%h", n, sw_out);

        // Random pin activity checked by the model on every edge.
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(5) == 0) sw_raw[b] = ~sw_raw[b];
            tick();
            $display("rnd %0d raw=%h out=%h rise=%h fall=%h chg=%0d",
                     i, sw_raw, sw_out, sw_rise, sw_fall, sw_change);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
